// File: rtl/writeback_pc_update_if.sv
// Bundle between the memory stage, decode read ports and the write-back/PC-update stage.
// The master drives the retiring instruction and the read addresses; the slave returns the architectural state.
interface writeback_pc_update_if;
    logic        instr_valid;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        imem_error;
    logic        instr_invalid;
    logic        dmem_error;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] rdA;
    logic [63:0] rdB;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] retired;

    modport master (
        output instr_valid, icode, rA, rB, cnd, valC, valP, valE, valM,
               imem_error, instr_invalid, dmem_error, srcA, srcB,
        input  rdA, rdB, pc, stat, halted, retired
    );

    modport slave (
        input  instr_valid, icode, rA, rB, cnd, valC, valP, valE, valM,
               imem_error, instr_invalid, dmem_error, srcA, srcB,
        output rdA, rdB, pc, stat, halted, retired
    );
endinterface

// File: rtl/writeback_pc_update.sv
// Y86-64 write-back and PC-update stage: register file, PC, processor status and retire counter.
// Register reads are combinational with no bypass; all architectural state freezes once status leaves AOK.
module writeback_pc_update #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input logic               clk,
    input logic               rst_n,
    writeback_pc_update_if.slave wb
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OP     = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSH   = 4'hA;
    localparam logic [3:0] I_POP    = 4'hB;

    logic [63:0] regs_q [0:14];
    logic [63:0] pc_q, pc_d;
    logic [2:0]  stat_q, stat_d;
    logic [31:0] retired_q;
    logic [3:0]  dst_e, dst_m;
    logic        retire;

    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (wb.icode)
            I_CMOV:                         dst_e = wb.cnd ? wb.rB : RNONE;
            I_IRMOV, I_OP:                  dst_e = wb.rB;
            I_CALL, I_RET, I_PUSH, I_POP:   dst_e = RSP;
            default:                        dst_e = RNONE;
        endcase
        if (wb.icode == I_MRMOV || wb.icode == I_POP)
            dst_m = wb.rA;
    end

    // Fault priority: fetch address, then illegal instruction, then data address, then halt.
    always_comb begin
        if (wb.imem_error)
            stat_d = STAT_ADR;
        else if (wb.instr_invalid)
            stat_d = STAT_INS;
        else if (wb.dmem_error)
            stat_d = STAT_ADR;
        else if (wb.icode == I_HALT)
            stat_d = STAT_HLT;
        else
            stat_d = STAT_AOK;
    end

    always_comb begin
        pc_d = wb.valP;
        case (wb.icode)
            I_CALL:  pc_d = wb.valC;
            I_JXX:   pc_d = wb.cnd ? wb.valC : wb.valP;
            I_RET:   pc_d = wb.valM;
            default: pc_d = wb.valP;
        endcase
    end

    assign retire = wb.instr_valid && (stat_q == STAT_AOK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++)
                regs_q[i] <= 64'd0;
            pc_q      <= RESET_PC;
            stat_q    <= STAT_AOK;
            retired_q <= 32'd0;
        end else if (retire) begin
            if (stat_d == STAT_AOK) begin
                // dstM is written last so it wins when both target the same register.
                if (dst_e != RNONE)
                    regs_q[dst_e] <= wb.valE;
                if (dst_m != RNONE)
                    regs_q[dst_m] <= wb.valM;
                pc_q      <= pc_d;
                retired_q <= retired_q + 32'd1;
            end else if (stat_d == STAT_HLT) begin
                pc_q      <= wb.valP;
                retired_q <= retired_q + 32'd1;
                stat_q    <= STAT_HLT;
            end else begin
                stat_q    <= stat_d;
            end
        end
    end

    assign wb.rdA     = (wb.srcA == RNONE) ? 64'd0 : regs_q[wb.srcA];
    assign wb.rdB     = (wb.srcB == RNONE) ? 64'd0 : regs_q[wb.srcB];
    assign wb.pc      = pc_q;
    assign wb.stat    = stat_q;
    assign wb.halted  = (stat_q != STAT_AOK);
    assign wb.retired = retired_q;
endmodule

// File: tb/tb_writeback_pc_update.sv
// Randomized and directed bench for writeback_pc_update against an architectural model of the stage.
module tb_writeback_pc_update;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    writeback_pc_update_if bus ();

    writeback_pc_update #(.RESET_PC(64'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    // Architectural model state
    logic [63:0] m_regs [0:14];
    logic [63:0] m_pc;
    logic [2:0]  m_stat;
    logic [31:0] m_ret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [3:0] a);
        return (a == 4'hF) ? 64'd0 : m_regs[a];
    endfunction

    // What the retiring instruction does to the machine, from the ISA rules.
    task automatic model_edge();
        logic [2:0] st;
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
            m_pc = 64'd0; m_stat = 3'd1; m_ret = 32'd0;
        end else if (bus.instr_valid && m_stat == 3'd1) begin
            if (bus.imem_error)         st = 3'd3;
            else if (bus.instr_invalid) st = 3'd4;
            else if (bus.dmem_error)    st = 3'd3;
            else if (bus.icode == 4'h0) st = 3'd2;
            else                        st = 3'd1;
            if (st == 3'd1) begin
                if ((bus.icode == 4'h2 && bus.cnd) || bus.icode == 4'h3 || bus.icode == 4'h6)
                    if (bus.rB != 4'hF) m_regs[bus.rB] = bus.valE;
                if (bus.icode >= 4'h8 && bus.icode <= 4'hB)
                    m_regs[4] = bus.valE;
                if ((bus.icode == 4'h5 || bus.icode == 4'hB) && bus.rA != 4'hF)
                    m_regs[bus.rA] = bus.valM;
                if (bus.icode == 4'h8 || (bus.icode == 4'h7 && bus.cnd)) m_pc = bus.valC;
                else if (bus.icode == 4'h9)                              m_pc = bus.valM;
                else                                                     m_pc = bus.valP;
                m_ret = m_ret + 1;
            end else if (st == 3'd2) begin
                m_pc = bus.valP; m_ret = m_ret + 1; m_stat = 3'd2;
            end else begin
                m_stat = st;
            end
        end
    endtask

    // One clock: advance model at the edge, then compare all outputs 1ns later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("pc", bus.pc, m_pc);
        chk("stat", 64'(bus.stat), 64'(m_stat));
        chk("halted", 64'(bus.halted), 64'(m_stat != 3'd1));
        chk("retired", 64'(bus.retired), 64'(m_ret));
        chk("rdA", bus.rdA, m_read(bus.srcA));
        chk("rdB", bus.rdB, m_read(bus.srcB));
    endtask

    task automatic idle();
        bus.instr_valid = 1'b0; bus.icode = 4'h1; bus.rA = 4'hF; bus.rB = 4'hF; bus.cnd = 1'b0;
        bus.valC = 64'd0; bus.valP = 64'd0; bus.valE = 64'd0; bus.valM = 64'd0;
        bus.imem_error = 1'b0; bus.instr_invalid = 1'b0; bus.dmem_error = 1'b0;
    endtask

    task automatic instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic [63:0] vc, input logic [63:0] vp,
                         input logic [63:0] ve, input logic [63:0] vm);
        idle();
        bus.instr_valid = 1'b1; bus.icode = ic; bus.rA = ra; bus.rB = rb; bus.cnd = c;
        bus.valC = vc; bus.valP = vp; bus.valE = ve; bus.valM = vm;
    endtask

    task automatic do_reset();
        idle(); rst_n = 1'b0; cyc(); rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] saved;
        idle();
        bus.srcA = 4'hF; bus.srcB = 4'hF;
        for (int i = 0; i < 15; i++) m_regs[i] = 64'hX;
        m_pc = 64'hX; m_stat = 3'hX; m_ret = 32'hX;

        do_reset();
        chk("rst_pc_lit", bus.pc, 64'd0);
        chk("rst_stat_lit", 64'(bus.stat), 64'd1);
        chk("rst_ret_lit", 64'(bus.retired), 64'd0);

        // irmovq into %rdx
        bus.srcB = 4'd2;
        instr(4'h3, 4'hF, 4'd2, 1'b0, 64'd0, 64'h0A, 64'h1234, 64'd0); cyc();
        chk("irmov_rd_lit", bus.rdB, 64'h1234);
        chk("irmov_pc_lit", bus.pc, 64'h0A);
        chk("irmov_ret_lit", 64'(bus.retired), 64'd1);

        // popq %rsp: valM wins over valE
        bus.srcA = 4'd4;
        instr(4'hB, 4'd4, 4'hF, 1'b0, 64'd0, 64'h0C, 64'h108, 64'hDEAD); cyc();
        chk("popq_rsp_lit", bus.rdA, 64'hDEAD);
        instr(4'h5, 4'hF, 4'd3, 1'b0, 64'd0, 64'h16, 64'h55, 64'h99); cyc();

        instr(4'h7, 4'hF, 4'hF, 1'b1, 64'h40, 64'h09, 64'd0, 64'd0); cyc();
        chk("jxx_taken_lit", bus.pc, 64'h40);
        instr(4'h7, 4'hF, 4'hF, 1'b0, 64'h40, 64'h09, 64'd0, 64'd0); cyc();
        chk("jxx_not_lit", bus.pc, 64'h09);
        instr(4'h8, 4'hF, 4'hF, 1'b0, 64'h80, 64'h12, 64'h100, 64'd0); cyc();
        chk("call_pc_lit", bus.pc, 64'h80);
        chk("call_rsp_lit", bus.rdA, 64'h100);
        instr(4'h9, 4'hF, 4'hF, 1'b0, 64'd0, 64'h81, 64'h108, 64'h77); cyc();
        chk("ret_pc_lit", bus.pc, 64'h77);

        // data fault at pc 0x20 freezes everything until reset
        instr(4'h3, 4'hF, 4'd2, 1'b0, 64'd0, 64'h20, 64'h5, 64'd0); cyc();
        saved = bus.rdB;
        instr(4'h4, 4'd2, 4'd3, 1'b0, 64'd0, 64'h2A, 64'h200, 64'd0);
        bus.dmem_error = 1'b1; cyc();
        chk("dmem_stat_lit", 64'(bus.stat), 64'd3);
        chk("dmem_halted_lit", 64'(bus.halted), 64'd1);
        chk("dmem_pc_lit", bus.pc, 64'h20);
        instr(4'h3, 4'hF, 4'd2, 1'b0, 64'd0, 64'h30, 64'h9999, 64'd0); cyc(); cyc();
        chk("frozen_reg", bus.rdB, saved);
        do_reset();
        chk("reset_stat_lit", 64'(bus.stat), 64'd1);
        chk("reset_reg_lit", bus.rdB, 64'd0);

        // halt retires once, then freezes
        instr(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'h31, 64'd0, 64'd0); cyc();
        chk("halt_stat_lit", 64'(bus.stat), 64'd2);
        chk("halt_pc_lit", bus.pc, 64'h31);
        chk("halt_ret_lit", 64'(bus.retired), 64'd1);
        instr(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'h40, 64'd0, 64'd0); cyc(); cyc();
        chk("halt_frozen_lit", 64'(bus.retired), 64'd1);
        do_reset();
        instr(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'h31, 64'd0, 64'd0);
        bus.imem_error = 1'b1; cyc();
        chk("imem_prio_lit", 64'(bus.stat), 64'd3);
        chk("imem_ret_lit", 64'(bus.retired), 64'd0);

        // counter wrap
        do_reset();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFF_FFFF;
        idle(); cyc();
        chk("idle_ret_lit", 64'(bus.retired), 64'hFFFF_FFFF);
        instr(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'h2, 64'd0, 64'd0); cyc();
        chk("wrap_ret_lit", 64'(bus.retired), 64'd0);

        // randomized traffic, with occasional faults, halts and resets
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            instr(4'($urandom_range(1, 11)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) bus.icode = 4'h0;
            if ($urandom_range(0, 80) == 0) bus.imem_error = 1'b1;
            if ($urandom_range(0, 80) == 0) bus.instr_invalid = 1'b1;
            if ($urandom_range(0, 80) == 0) bus.dmem_error = 1'b1;
            rst_n = ($urandom_range(0, 50) != 0) && !(bus.halted && $urandom_range(0, 4) == 0);
            bus.srcA = 4'($urandom_range(0, 15));
            bus.srcB = 4'($urandom_range(0, 15));
            cyc();
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
